// File: rtl/irq_pending_ctrl.sv
// Sticky 4-line interrupt pending register with enable mask, fixed priority
// (bit 3 highest) and a valid/ack presentation handshake with one-cycle holdoff.
module irq_pending_ctrl #(
  parameter bit LEVEL_MODE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       mask_wr,
  input  logic [3:0] mask_in,
  input  logic       ack,
  input  logic       ovf_clr,
  output logic [3:0] pend,
  output logic       irq_valid,
  output logic [1:0] irq_id,
  output logic [3:0] overflow
);

  localparam int unsigned N_LINES = 4;
  localparam int unsigned ID_W    = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [N_LINES-1:0]  req_q;
  logic [N_LINES-1:0]  mask;
  logic [N_LINES-1:0]  rise;
  logic [N_LINES-1:0]  clr;
  logic [N_LINES-1:0]  eligible;
  logic [ID_W-1:0]     id_d;
  logic                valid_d;

  function automatic logic [ID_W-1:0] top_index(input logic [N_LINES-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_LINES; i++) begin
      if (v[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

  assign rise     = LEVEL_MODE ? req : (req & ~req_q);
  assign clr      = (state == PRESENT && ack) ? (N_LINES'(1) << irq_id) : '0;
  assign eligible = pend & mask;

  // Capture, mask and overflow registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q    <= '0;
      pend     <= '0;
      overflow <= '0;
      mask     <= '1;
    end else begin
      req_q <= req;
      pend  <= rise | (pend & ~clr);
      for (int i = 0; i < N_LINES; i++) begin
        if (rise[i] && pend[i] && !clr[i]) overflow[i] <= 1'b1;
        else if (ovf_clr)                  overflow[i] <= 1'b0;
      end
      if (mask_wr) mask <= mask_in;
    end
  end

  // Handshake state register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      irq_valid <= 1'b0;
      irq_id    <= '0;
    end else begin
      state     <= state_d;
      irq_valid <= valid_d;
      irq_id    <= id_d;
    end
  end

  // Next-state: present highest eligible line, hold it until ack, then one low cycle
  always_comb begin
    state_d = state;
    valid_d = 1'b0;
    id_d    = '0;
    unique case (state)
      IDLE, HOLDOFF: begin
        state_d = IDLE;
        if (eligible != '0) begin
          state_d = PRESENT;
          valid_d = 1'b1;
          id_d    = top_index(eligible);
        end
      end
      PRESENT: begin
        if (ack) begin
          state_d = HOLDOFF;
        end else begin
          valid_d = 1'b1;
          id_d    = irq_id;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl: edge-mode instance plus a level-mode instance.
module tb_irq_pending_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       mask_wr;
  logic [3:0] mask_in;
  logic       ack;
  logic       ovf_clr;

  logic [3:0] pend, overflow;
  logic       irq_valid;
  logic [1:0] irq_id;
  logic [3:0] pend_l, overflow_l;
  logic       irq_valid_l;
  logic [1:0] irq_id_l;

  int total = 0;
  int bad   = 0;

  irq_pending_ctrl #(.LEVEL_MODE(1'b0)) dut (
    .clk(clk), .rst(rst), .req(req), .mask_wr(mask_wr), .mask_in(mask_in),
    .ack(ack), .ovf_clr(ovf_clr), .pend(pend), .irq_valid(irq_valid),
    .irq_id(irq_id), .overflow(overflow)
  );

  irq_pending_ctrl #(.LEVEL_MODE(1'b1)) dut_lvl (
    .clk(clk), .rst(rst), .req(req), .mask_wr(mask_wr), .mask_in(mask_in),
    .ack(ack), .ovf_clr(ovf_clr), .pend(pend_l), .irq_valid(irq_valid_l),
    .irq_id(irq_id_l), .overflow(overflow_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; mask_wr = 1'b0; mask_in = '0; ack = 1'b0; ovf_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (pend !== 4'b0000) begin bad++; $display("FAIL reset_pend got=%b exp=0000", pend); end
    total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", irq_valid); end
    total++; if (irq_id !== 2'b00) begin bad++; $display("FAIL reset_id got=%b exp=00", irq_id); end
    total++; if (overflow !== 4'b0000) begin bad++; $display("FAIL reset_ovf got=%b exp=0000", overflow); end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    tick();
    total++; if (pend !== 4'b0100) begin bad++; $display("FAIL single_pend got=%b exp=0100", pend); end
    total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b exp=0", irq_valid); end
    tick();
    total++; if (irq_valid !== 1'b1 || irq_id !== 2'b10) begin bad++; $display("FAIL single_present got=%b/%b exp=1/10", irq_valid, irq_id); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    total++; if (pend !== 4'b0000 || irq_valid !== 1'b0) begin bad++; $display("FAIL single_ack got=%b/%b exp=0000/0", pend, irq_valid); end
    tick();
    tick();
    total++; if (pend !== 4'b0000 || irq_valid !== 1'b0) begin bad++; $display("FAIL single_noretrig got=%b/%b exp=0000/0", pend, irq_valid); end
    req = '0;
  endtask

  task automatic test_priority();
    do_reset();
    req = 4'b0011;
    tick();
    total++; if (pend !== 4'b0011) begin bad++; $display("FAIL prio_pend got=%b exp=0011", pend); end
    tick();
    total++; if (irq_valid !== 1'b1 || irq_id !== 2'b01) begin bad++; $display("FAIL prio_first got=%b/%b exp=1/01", irq_valid, irq_id); end
    req = 4'b1011;
    tick();
    req = 4'b0000;
    total++; if (pend !== 4'b1011 || irq_id !== 2'b01 || irq_valid !== 1'b1) begin bad++; $display("FAIL prio_nopreempt got=%b/%b/%b exp=1011/01/1", pend, irq_id, irq_valid); end
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    total++; if (irq_valid !== 1'b0 || pend !== 4'b1001) begin bad++; $display("FAIL prio_gap got=%b/%b exp=0/1001", irq_valid, pend); end
    tick();
    total++; if (irq_valid !== 1'b1 || irq_id !== 2'b11) begin bad++; $display("FAIL prio_second got=%b/%b exp=1/11", irq_valid, irq_id); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    total++; if (irq_valid !== 1'b1 || irq_id !== 2'b00 || pend !== 4'b0001) begin bad++; $display("FAIL prio_third got=%b/%b/%b exp=1/00/0001", irq_valid, irq_id, pend); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    total++; if (irq_valid !== 1'b0 || pend !== 4'b0000 || irq_id !== 2'b00) begin bad++; $display("FAIL prio_idle got=%b/%b/%b exp=0/0000/00", irq_valid, pend, irq_id); end
  endtask

  task automatic test_mask();
    do_reset();
    mask_wr = 1'b1; mask_in = 4'b0111;
    tick();
    mask_wr = 1'b0;
    req = 4'b1010;
    tick();
    req = 4'b0000;
    total++; if (pend !== 4'b1010) begin bad++; $display("FAIL mask_pend got=%b exp=1010", pend); end
    tick();
    total++; if (irq_valid !== 1'b1 || irq_id !== 2'b01) begin bad++; $display("FAIL mask_present got=%b/%b exp=1/01", irq_valid, irq_id); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    total++; if (irq_valid !== 1'b0 || pend !== 4'b1000) begin bad++; $display("FAIL mask_after_ack got=%b/%b exp=0/1000", irq_valid, pend); end
    tick();
    tick();
    total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL mask_blocked got=%b exp=0", irq_valid); end
    mask_wr = 1'b1; mask_in = 4'b1111;
    tick();
    mask_wr = 1'b0;
    total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL mask_wr_early got=%b exp=0", irq_valid); end
    tick();
    total++; if (irq_valid !== 1'b1 || irq_id !== 2'b11) begin bad++; $display("FAIL mask_unmask got=%b/%b exp=1/11", irq_valid, irq_id); end
  endtask

  task automatic test_overflow();
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    total++; if (overflow !== 4'b0000) begin bad++; $display("FAIL ovf_first got=%b exp=0000", overflow); end
    tick();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    total++; if (overflow !== 4'b0100) begin bad++; $display("FAIL ovf_second got=%b exp=0100", overflow); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    total++; if (overflow !== 4'b0000) begin bad++; $display("FAIL ovf_clear got=%b exp=0000", overflow); end
    total++; if (irq_valid !== 1'b1 || irq_id !== 2'b10) begin bad++; $display("FAIL ovf_present got=%b/%b exp=1/10", irq_valid, irq_id); end
    ack = 1'b1; req = 4'b0100;
    tick();
    ack = 1'b0; req = 4'b0000;
    total++; if (pend !== 4'b0100 || overflow !== 4'b0000 || irq_valid !== 1'b0) begin bad++; $display("FAIL ovf_race got=%b/%b/%b exp=0100/0000/0", pend, overflow, irq_valid); end
    tick();
    total++; if (irq_valid !== 1'b1 || irq_id !== 2'b10) begin bad++; $display("FAIL ovf_represent got=%b/%b exp=1/10", irq_valid, irq_id); end
    req = 4'b0100; ovf_clr = 1'b1;
    tick();
    req = 4'b0000;
    total++; if (overflow !== 4'b0100) begin bad++; $display("FAIL ovf_set_wins got=%b exp=0100", overflow); end
    tick();
    ovf_clr = 1'b0;
    total++; if (overflow !== 4'b0000) begin bad++; $display("FAIL ovf_clear2 got=%b exp=0000", overflow); end
  endtask

  task automatic test_level();
    do_reset();
    req = 4'b0001;
    tick();
    total++; if (pend_l !== 4'b0001) begin bad++; $display("FAIL lvl_pend got=%b exp=0001", pend_l); end
    tick();
    for (int n = 0; n < 3; n++) begin
      total++; if (irq_valid_l !== 1'b1 || irq_id_l !== 2'b00) begin bad++; $display("FAIL lvl_present%0d got=%b/%b exp=1/00", n, irq_valid_l, irq_id_l); end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      total++; if (irq_valid_l !== 1'b0 || pend_l !== 4'b0001) begin bad++; $display("FAIL lvl_gap%0d got=%b/%b exp=0/0001", n, irq_valid_l, pend_l); end
      tick();
    end
    total++; if (pend !== 4'b0000 || irq_valid !== 1'b0) begin bad++; $display("FAIL lvl_edge_inst got=%b/%b exp=0000/0", pend, irq_valid); end
    req = 4'b0000;
  endtask

  task automatic test_async_reset();
    do_reset();
    mask_wr = 1'b1; mask_in = 4'b0111;
    tick();
    mask_wr = 1'b0;
    req = 4'b1001;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b1000;
    tick();
    req = 4'b0000;
    total++; if (irq_valid !== 1'b1 || irq_id !== 2'b00 || overflow !== 4'b1000) begin bad++; $display("FAIL arst_pre got=%b/%b/%b exp=1/00/1000", irq_valid, irq_id, overflow); end
    #2 rst = 1'b1;
    #1;
    total++; if (pend !== 4'b0000 || irq_valid !== 1'b0 || irq_id !== 2'b00 || overflow !== 4'b0000) begin bad++; $display("FAIL arst_now got=%b/%b/%b/%b exp=0000/0/00/0000", pend, irq_valid, irq_id, overflow); end
    #1 rst = 1'b0;
    req = 4'b1000;
    tick();
    tick();
    req = 4'b0000;
    total++; if (irq_valid !== 1'b1 || irq_id !== 2'b11) begin bad++; $display("FAIL arst_mask got=%b/%b exp=1/11", irq_valid, irq_id); end
  endtask

  task automatic test_stray_ack();
    do_reset();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    total++; if (pend !== 4'b0000 || irq_valid !== 1'b0) begin bad++; $display("FAIL stray_empty got=%b/%b exp=0000/0", pend, irq_valid); end
    mask_wr = 1'b1; mask_in = 4'b0000;
    tick();
    mask_wr = 1'b0;
    req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    total++; if (pend !== 4'b0010 || irq_valid !== 1'b0 || irq_id !== 2'b00) begin bad++; $display("FAIL stray_idle got=%b/%b/%b exp=0010/0/00", pend, irq_valid, irq_id); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_overflow();
    test_level();
    test_async_reset();
    test_stray_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
